// File: rtl/enc_pkg.sv
// enc_pkg: shared sizes and helpers for the 16-to-4 sequential request encoder.
//   N_REQ    number of request lines (16)
//   IDX_W    index width, log2(N_REQ) (4)
//   onehot16 index -> one-hot request mask
//   rotl16 / rotr16  rotate a 16-bit vector by a 4-bit amount (round-robin search)
package enc_pkg;

    localparam int unsigned N_REQ = 16;
    localparam int unsigned IDX_W = 4;

    // One-hot mask for a single index.
    function automatic logic [N_REQ-1:0] onehot16(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

    // Rotate left by n, wrapping modulo 16.
    function automatic logic [N_REQ-1:0] rotl16(input logic [N_REQ-1:0] v,
                                                input logic [IDX_W-1:0] n);
        logic [2*N_REQ-1:0] dbl;
        dbl = {v, v} << n;
        return dbl[2*N_REQ-1:N_REQ];
    endfunction

    // Rotate right by n, wrapping modulo 16.
    function automatic logic [N_REQ-1:0] rotr16(input logic [N_REQ-1:0] v,
                                                input logic [IDX_W-1:0] n);
        logic [2*N_REQ-1:0] dbl;
        dbl = {v, v} >> n;
        return dbl[N_REQ-1:0];
    endfunction

endpackage

// File: rtl/enc16to4_seq_if.sv
// enc16to4_seq_if: request/issue bus of the sequential encoder.
//   EN, req   request capture enable and request lines (producer -> encoder)
//   out_idx, valid, ready  issue handshake (encoder -> consumer, ready back)
//   pend      pending-request status
// slave is the encoder side; master is the driving/consuming side.
interface enc16to4_seq_if;
    import enc_pkg::*;

    logic             EN;
    logic [N_REQ-1:0] req;
    logic [IDX_W-1:0] out_idx;
    logic             valid;
    logic             ready;
    logic [N_REQ-1:0] pend;

    modport master (output EN, req, ready, input out_idx, valid, pend);
    modport slave  (input EN, req, ready, output out_idx, valid, pend);

endinterface

// File: rtl/pri_enc4.sv
// pri_enc4: 4-bit lowest-set-bit priority encoder.
//   d      4-bit input
//   idx_c  index of the lowest set bit (0 when d == 0)
//   any_c  d has at least one bit set
module pri_enc4 (
    input  logic [3:0] d,
    output logic [1:0] idx_c,
    output logic       any_c
);

    always_comb begin
        idx_c = 2'd0;
        any_c = |d;
        if (d[0])      idx_c = 2'd0;
        else if (d[1]) idx_c = 2'd1;
        else if (d[2]) idx_c = 2'd2;
        else if (d[3]) idx_c = 2'd3;
    end

endmodule

// File: rtl/enc16to4_seq.sv
// enc16to4_seq: sequential 16-to-4 request encoder with valid/ready issue.
// Requests merge into a pending register; one index is issued per accepted
// transfer and its pending bit is cleared as it is loaded into the slot.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         enc16to4_seq_if.slave (EN, req, ready in; out_idx, valid, pend out)
// Build option ENC16TO4_ROUND_ROBIN_EN: rotating priority starting at ptr.
// Default build: fixed lowest-index priority, no ptr register.
module enc16to4_seq
    import enc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    enc16to4_seq_if.slave      bus
);

    logic [N_REQ-1:0]       pend_q, pend_n;
    logic [IDX_W-1:0]       idx_q, idx_n;
    logic                   valid_q, valid_n;
    logic [N_REQ-1:0]       cand;
    logic [N_REQ-1:0]       enc_in;
    logic [3:0][1:0]        grp_idx;
    logic [3:0]             grp_any;
    logic [1:0]             grp_sel;
    logic                   cand_any;
    logic [IDX_W-1:0]       enc_idx;
    logic [IDX_W-1:0]       sel_idx;
    logic                   fire;

`ifdef ENC16TO4_ROUND_ROBIN_EN
    logic [IDX_W-1:0]       ptr_q, ptr_n;
`endif

    // Candidate set: pending bits plus this cycle's captured requests.
    always_comb begin
        cand = pend_q | (bus.EN ? bus.req : '0);
        fire = valid_q & bus.ready;
    end

    // Search window: rotated so that ptr becomes bit 0 in round-robin mode.
`ifdef ENC16TO4_ROUND_ROBIN_EN
    always_comb enc_in = rotr16(cand, ptr_q);
`else
    always_comb enc_in = cand;
`endif

    // Two-level tree: four group encoders, then a selector over group hits.
    for (genvar g = 0; g < 4; g++) begin : g_grp
        pri_enc4 u_grp (
            .d     (enc_in[4*g +: 4]),
            .idx_c (grp_idx[g]),
            .any_c (grp_any[g])
        );
    end

    pri_enc4 u_sel (
        .d     (grp_any),
        .idx_c (grp_sel),
        .any_c (cand_any)
    );

    always_comb begin
        enc_idx = {grp_sel, grp_idx[grp_sel]};
`ifdef ENC16TO4_ROUND_ROBIN_EN
        sel_idx = IDX_W'(enc_idx + ptr_q);
`else
        sel_idx = enc_idx;
`endif
    end

    // Next-state: load the slot when empty or firing, otherwise hold and absorb.
    always_comb begin
        pend_n  = pend_q;
        idx_n   = idx_q;
        valid_n = valid_q;
`ifdef ENC16TO4_ROUND_ROBIN_EN
        ptr_n   = ptr_q;
`endif
        if (!valid_q || fire) begin
            if (cand_any) begin
                idx_n   = sel_idx;
                valid_n = 1'b1;
                pend_n  = cand & ~onehot16(sel_idx);
`ifdef ENC16TO4_ROUND_ROBIN_EN
                ptr_n   = IDX_W'(sel_idx + IDX_W'(1));
`endif
            end else begin
                valid_n = 1'b0;
                pend_n  = '0;
            end
        end else begin
            // Stalled: a request for the held index is absorbed, not re-pended.
            pend_n = cand & ~onehot16(idx_q);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
`ifdef ENC16TO4_ROUND_ROBIN_EN
            ptr_q   <= '0;
`endif
        end else begin
            pend_q  <= pend_n;
            idx_q   <= idx_n;
            valid_q <= valid_n;
`ifdef ENC16TO4_ROUND_ROBIN_EN
            ptr_q   <= ptr_n;
`endif
        end
    end

    assign bus.out_idx = idx_q;
    assign bus.valid   = valid_q;
    assign bus.pend    = pend_q;

endmodule
